sm_imem_loader: RTL and testbench
=================================

SM_IMEM_LOADER -- requirements
Module: sm_imem_loader

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  ADDR_W   6        instruction memory word-address width; capacity 2**ADDR_W words
  TIMEOUT  1000000  maximum clk cycles between bytes within a frame
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk        in   1       single clock; all state changes on its rising edge
  rst_n      in   1       reset, asynchronous, active-low
  rx_valid   in   1       byte-stream valid
  rx_data    in   8       byte-stream data
  rx_ready   out  1       loader accepts a byte when rx_valid & rx_ready
  wr_en      out  1       instruction memory write strobe, one cycle per word
  wr_addr    out  ADDR_W  word address for wr_en
  wr_data    out  32      word to write
  cpu_rst_n  out  1       active-low reset to the CPU core; low while loading
  busy       out  1       frame in progress
  done       out  1       last frame loaded and checksum matched
  err        out  1       last frame aborted
REQ-003 One clock domain; reset is asynchronous, active-low; no other clock or reset inputs.

Function
REQ-004 Frame format: 0xA5 magic; LEN_L; LEN_H (16-bit word count, little-endian); LEN words, each 4 bytes little-endian (first byte = wr_data[7:0]); CSUM byte = XOR of all data bytes (XOR of zero bytes = 0x00).
REQ-005 States: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-006 IDLE/DONE/ERR: magic 0xA5 accepted -> LEN0; any other accepted byte is discarded with no state change.
REQ-007 LEN0 -> LEN1 on next byte; LEN1 -> DATA if 1 <= LEN <= 2**ADDR_W, -> CSUM if LEN == 0, -> ERR if LEN > 2**ADDR_W.
REQ-008 DATA: bytes assembled into a 32-bit word; on acceptance of the 4th byte, the next cycle drives wr_en=1 for exactly one cycle with wr_addr = word index (first word 0) and wr_data = assembled word.
REQ-009 rx_ready is 0 in the cycle wr_en=1 and 1 in every other cycle after reset.
REQ-010 Word index increments after each write; after word LEN-1 is written -> CSUM; index never wraps, guaranteed by REQ-007.
REQ-011 CSUM: received byte equal to running XOR -> DONE; unequal -> ERR.
REQ-012 Timeout: in LEN0, LEN1, DATA or CSUM, TIMEOUT consecutive cycles without an accepted byte -> ERR. The counter clears on every accepted byte and on entry to LEN0.
REQ-013 busy = 1 in LEN0, LEN1, DATA and CSUM; done = 1 only in DONE; err = 1 only in ERR.
REQ-014 cpu_rst_n is registered: it goes 0 in the cycle after magic is accepted, and goes 1 in the cycle after entry to DONE. It stays 0 in ERR and returns to 1 only after a later successful frame.
REQ-015 A magic byte received in DONE or ERR starts a new frame, clears done/err, clears the checksum and word index, and drives cpu_rst_n low.
REQ-016 0xA5 inside LEN/DATA/CSUM is treated as data, not as a frame restart.
REQ-017 Words already written before ERR are not rolled back.

Reset
REQ-018 rst_n low asynchronously forces: state IDLE, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0, rx_ready=0, cpu_rst_n=0, checksum/index/timeout counters = 0.
REQ-019 First clk edge after rst_n high: rx_ready=1 and cpu_rst_n=1, so the CPU runs the preloaded memory image.
REQ-020 rst_n asserted mid-frame aborts the frame immediately and applies REQ-018 with no further writes.

Verification
REQ-021 Frame A5 02 00 | 11 22 33 44 | 55 66 77 88 | 88 -> writes addr0=0x44332211 and addr1=0x88776655. cpu_rst_n is low from the cycle after A5 until the cycle after the CSUM byte, then done=1.
REQ-022 Frame A5 00 00 00 -> no wr_en pulses, done=1, cpu_rst_n=1; the same frame with final byte 01 gives err=1 and cpu_rst_n=0.
REQ-023 ADDR_W=6, LEN=0x0041 -> ERR after LEN_H, no wr_en; a following valid frame -> done=1, err=0.
REQ-024 Idle bytes 00 FF 5A before A5 are ignored; data byte A5 mid-word is stored as data; back-to-back rx_valid shows rx_ready low exactly one cycle per word.
REQ-025 TIMEOUT=16: stall 16 cycles after the 2nd data byte -> err=1; stall 15 cycles -> frame completes normally.
REQ-026 rst_n pulsed low after 5 data bytes -> all outputs at reset values asynchronously; no further wr_en; cpu_rst_n=1 one edge after release.

Source files
------------

// File: rtl/sm_imem_loader.sv
// Byte-stream boot loader: receives a framed instruction image and writes it into the
// instruction memory, holding the CPU in reset while a frame is being loaded.
//
// state | meaning
// IDLE  | after reset, CPU runs preloaded image, waiting for magic
// LEN0  | expecting word count low byte
// LEN1  | expecting word count high byte
// DATA  | assembling 4-byte words and writing them
// CSUM  | expecting XOR checksum byte
// DONE  | frame loaded and verified, CPU released
// ERR   | frame aborted, CPU held in reset
module sm_imem_loader #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  state_t            state, stateNext;
  logic              accept, isMagic, waitMagic, lastByte, lastWord, timedOut;
  logic [16:0]       lenFull;
  logic [7:0]        lenLo, csum;
  logic [1:0]        byteCnt;
  logic [23:0]       wordLo;
  logic [ADDR_W-1:0] wordIdx, lastIdx;
  logic [TW-1:0]     toCnt;

  assign accept    = rx_valid & rx_ready;
  assign isMagic   = (rx_data == 8'hA5);
  assign waitMagic = (state == IDLE) || (state == DONE) || (state == ERR);
  assign lenFull   = {1'b0, rx_data, lenLo};
  assign lastByte  = (byteCnt == 2'd3);
  assign lastWord  = (wordIdx == lastIdx);
  assign busy      = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign timedOut  = busy && !accept && (toCnt == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (timedOut) begin
      stateNext = ERR;
    end else if (accept) begin
      case (state)
        IDLE, DONE, ERR: if (isMagic) stateNext = LEN0;
        LEN0:            stateNext = LEN1;
        LEN1: begin
          if (lenFull == 17'd0)       stateNext = CSUM;
          else if (lenFull > DEPTH)   stateNext = ERR;
          else                        stateNext = DATA;
        end
        DATA:            if (lastByte && lastWord) stateNext = CSUM;
        CSUM:            stateNext = (rx_data == csum) ? DONE : ERR;
        default:         stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_ready  <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      cpu_rst_n <= 1'b0;
      lenLo     <= '0;
      lastIdx   <= '0;
      csum      <= '0;
      byteCnt   <= '0;
      wordLo    <= '0;
      wordIdx   <= '0;
      toCnt     <= '0;
    end else begin
      wr_en    <= 1'b0;
      // the write cycle is the only cycle the loader refuses bytes
      rx_ready <= !(accept && (state == DATA) && lastByte);

      if (accept && waitMagic && isMagic)        cpu_rst_n <= 1'b0;
      else if ((state == IDLE) || (state == DONE)) cpu_rst_n <= 1'b1;

      if (accept)    toCnt <= TW'(TIMEOUT);
      else if (busy) toCnt <= toCnt - TW'(1);

      if (accept) begin
        case (state)
          IDLE, DONE, ERR: begin
            if (isMagic) begin
              csum    <= '0;
              wordIdx <= '0;
              byteCnt <= '0;
            end
          end
          LEN0: lenLo   <= rx_data;
          LEN1: lastIdx <= ADDR_W'(lenFull - 17'd1);
          DATA: begin
            csum    <= csum ^ rx_data;
            byteCnt <= byteCnt + 2'd1;
            case (byteCnt)
              2'd0:    wordLo[7:0]   <= rx_data;
              2'd1:    wordLo[15:8]  <= rx_data;
              2'd2:    wordLo[23:16] <= rx_data;
              default: begin
                wr_en   <= 1'b1;
                wr_addr <= wordIdx;
                wr_data <= {rx_data, wordLo};
                if (!lastWord) wordIdx <= wordIdx + ADDR_W'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sm_imem_loader.sv
// Directed bench for sm_imem_loader: expected writes go into a scoreboard queue as words
// are sent and are popped by a monitor whenever wr_en pulses.
module tb_sm_imem_loader;

  localparam int ADDR_W  = 6;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, wr_en, cpu_rst_n, busy, done, err;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  int          errors = 0;
  int          checks = 0;
  int          wrCount = 0;
  int          lowCnt = 0;
  bit          armed = 1'b0;
  logic [7:0]  runCsum;
  logic [37:0] expQ[$];

  sm_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .cpu_rst_n(cpu_rst_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (armed) begin
        check("ready_vs_wren", {31'd0, rx_ready}, {31'd0, !wr_en});
        if (!rx_ready) lowCnt++;
      end
      if (wr_en) begin
        logic [37:0] e;
        wrCount++;
        checks++;
        assert (expQ.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_write observed addr=%0h data=%0h expected no write", wr_addr, wr_data);
        end
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          check("wr_addr", 32'(wr_addr), 32'(e[37:32]));
          check("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 8) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (n < 8) else begin
      errors++;
      $error("FAIL send_stall observed ready_wait=%0d expected <8", n);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic sendHeader(input logic [15:0] len);
    sendByte(8'hA5);
    sendByte(len[7:0]);
    sendByte(len[15:8]);
    runCsum = 8'h00;
  endtask

  task automatic sendWord(input logic [31:0] w, input logic [5:0] addr);
    expQ.push_back({addr, w});
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      runCsum = runCsum ^ b;
      sendByte(b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int wrBase;
    logic [31:0] w;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_rx_ready",  32'(rx_ready), 0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_done",      32'(done), 0);
    check("rst_err",       32'(err), 0);
    check("rst_wr_en",     32'(wr_en), 0);
    check("rst_wr_addr",   32'(wr_addr), 0);
    check("rst_wr_data",   wr_data, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_rx_ready",  32'(rx_ready), 1);
    check("rel_cpu_rst_n", 32'(cpu_rst_n), 1);
    armed = 1'b1;

    // idle garbage ignored
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h5A);
    check("idle_busy", 32'(busy), 0);
    check("idle_cpu_rst_n", 32'(cpu_rst_n), 1);

    // two-word frame
    sendByte(8'hA5);
    check("magic_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("magic_busy", 32'(busy), 1);
    sendByte(8'h02);
    sendByte(8'h00);
    runCsum = 8'h00;
    sendWord(32'h44332211, 6'd0);
    sendWord(32'h88776655, 6'd1);
    check("a_cpu_low_before_csum", 32'(cpu_rst_n), 0);
    sendByte(8'h88);
    check("a_done", 32'(done), 1);
    check("a_err",  32'(err), 0);
    check("a_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    check("a_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("a_wr_count", wrCount, 2);

    // empty frames
    sendHeader(16'd0);
    sendByte(8'h00);
    check("z_done", 32'(done), 1);
    @(posedge clk);
    #1;
    check("z_cpu_rst_n", 32'(cpu_rst_n), 1);
    sendHeader(16'd0);
    sendByte(8'h01);
    check("zbad_err",  32'(err), 1);
    check("zbad_done", 32'(done), 0);
    repeat (3) @(posedge clk);
    #1;
    check("zbad_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("z_wr_count", wrCount, 2);

    // over-length
    sendHeader(16'h0041);
    check("long_err", 32'(err), 1);
    repeat (3) @(posedge clk);
    #1;
    check("long_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("long_wr_count", wrCount, 2);

    // recovery with 0xA5 as data
    sendHeader(16'd2);
    sendWord(32'h44A52211, 6'd0);
    sendWord(32'h0000A500, 6'd1);
    sendByte(runCsum);
    check("rec_done", 32'(done), 1);
    check("rec_err",  32'(err), 0);
    @(posedge clk);
    #1;
    check("rec_cpu_rst_n", 32'(cpu_rst_n), 1);

    // full-capacity back-to-back frame
    wrBase = wrCount;
    lowCnt = 0;
    sendHeader(16'd64);
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      sendWord(w, 6'(i));
    end
    sendByte(runCsum);
    check("max_done", 32'(done), 1);
    check("max_wr_count", wrCount - wrBase, 64);
    check("max_ready_low", lowCnt, 64);

    // timeout: 16 idle cycles aborts
    sendHeader(16'd1);
    sendByte(8'h10);
    sendByte(8'h20);
    repeat (15) @(posedge clk);
    #1;
    check("to_busy_at_15", 32'(busy), 1);
    @(posedge clk);
    #1;
    check("to_err", 32'(err), 1);
    check("to_cpu_rst_n", 32'(cpu_rst_n), 0);

    // 15 idle cycles tolerated
    sendHeader(16'd1);
    expQ.push_back({6'd0, 32'hD4C3B2A1});
    sendByte(8'hA1);
    sendByte(8'hB2);
    repeat (15) @(posedge clk);
    #1;
    sendByte(8'hC3);
    sendByte(8'hD4);
    sendByte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4);
    check("to15_done", 32'(done), 1);
    check("to15_err",  32'(err), 0);

    // asynchronous reset mid-frame
    sendHeader(16'd2);
    sendWord(32'h0BADF00D, 6'd0);
    sendByte(8'h77);
    wrBase = wrCount;
    #3;
    armed = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en",     32'(wr_en), 0);
    check("mid_rst_rx_ready",  32'(rx_ready), 0);
    check("mid_rst_busy",      32'(busy), 0);
    check("mid_rst_cpu_rst_n", 32'(cpu_rst_n), 0);
    check("mid_rst_done",      32'(done), 0);
    check("mid_rst_err",       32'(err), 0);
    check("mid_rst_wr_addr",   32'(wr_addr), 0);
    check("mid_rst_wr_data",   wr_data, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_rx_ready",  32'(rx_ready), 1);
    check("mid_rel_cpu_rst_n", 32'(cpu_rst_n), 1);
    check("mid_rel_busy",      32'(busy), 0);
    armed = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("mid_no_more_writes", wrCount - wrBase, 0);
    check("queue_empty", expQ.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
